// File: rtl/bram2fifo_pkg.sv
// Shared JRT constants: drain FSM state encodings and default drain geometry.
package bram2fifo_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StCapture = 3'd2,
    StPush    = 3'd3,
    StDone    = 3'd4
  } drain_state_e;

  localparam int unsigned NWordsDefault   = 6;
  localparam logic [31:0] BaseAddrDefault = 32'h0;
  localparam int unsigned WordCntW        = 16;

endpackage

// File: rtl/bram2fifo.sv
// Drains NWORDS result words from the JRT BRAM into a FIFO once the
// average module drops its busy flag.
module bram2fifo
  import bram2fifo_pkg::*;
#(
  parameter int unsigned NWORDS    = NWordsDefault,
  parameter logic [31:0] BASE_ADDR = BaseAddrDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        o_average_busy,
  output logic        ce,
  output logic        r_w_1,
  output logic [31:0] o_average_addr_1,
  input  logic [31:0] dataout_1,
  output logic [31:0] din,
  output logic        we,
  input  logic        full,
  output logic        drain_busy,
  output logic        drain_done
);

  localparam logic [WordCntW-1:0] LastWord = 16'(NWORDS - 1);

  drain_state_e        state_q, state_d;
  logic                busy_q;
  logic [31:0]         addr_q, addr_d;
  logic [WordCntW-1:0] cnt_q, cnt_d;
  logic [31:0]         hold_q, hold_d;
  logic [31:0]         din_q, din_d;
  logic                trigger;

  assign trigger = busy_q & ~o_average_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= o_average_busy;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    din_d      = din_q;
    ce         = 1'b0;
    we         = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          addr_d  = BASE_ADDR;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        ce      = 1'b1;
        state_d = StCapture;
      end
      StCapture: begin
        hold_d  = dataout_1;
        state_d = StPush;
      end
      StPush: begin
        // Back-pressure simply parks here; nothing advances until full drops.
        if (!full) begin
          we      = 1'b1;
          din_d   = hold_q;
          addr_d  = addr_q + 32'd1;
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_q == LastWord) ? StDone : StIssue;
        end
      end
      StDone: begin
        drain_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign r_w_1            = 1'b0;
  assign o_average_addr_1 = addr_q;
  // din shows the word being written, otherwise the last word written.
  assign din              = we ? hold_q : din_q;
  assign drain_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_bram2fifo.sv
// Randomised self-checking bench for bram2fifo: BRAM model, FIFO-side monitor
// and an expected-word list derived from base address and word count.
module tb_bram2fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy, ce, r_w_1, we, full, drain_busy, drain_done;
  logic [31:0] addr, dataout, din;
  logic        busy2, ce2, rw2, we2, full2, dbusy2, ddone2;
  logic [31:0] addr2, dout2, din2;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic        use_seq = 1'b1;
  logic [31:0] seed = 32'h0;

  logic [31:0] got_q[$];
  int          got_cyc[$];
  logic [31:0] addr_q[$];
  logic [31:0] got2_q[$];
  logic [31:0] addr2_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          done2_cnt = 0;
  int          viol = 0;

  always #5 clk = ~clk;

  bram2fifo u_dut (
    .clk              (clk),
    .reset            (reset),
    .o_average_busy   (busy),
    .ce               (ce),
    .r_w_1            (r_w_1),
    .o_average_addr_1 (addr),
    .dataout_1        (dataout),
    .din              (din),
    .we               (we),
    .full             (full),
    .drain_busy       (drain_busy),
    .drain_done       (drain_done)
  );

  bram2fifo #(
    .NWORDS    (4),
    .BASE_ADDR (32'hFFFF_FFFE)
  ) u_wrap (
    .clk              (clk),
    .reset            (reset),
    .o_average_busy   (busy2),
    .ce               (ce2),
    .r_w_1            (rw2),
    .o_average_addr_1 (addr2),
    .dataout_1        (dout2),
    .din              (din2),
    .we               (we2),
    .full             (full2),
    .drain_busy       (dbusy2),
    .drain_done       (ddone2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return use_seq ? 32'hA0 + a : (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // BRAM: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ce) dataout <= mem_word(addr);
    if (ce2) dout2 <= mem_word(addr2);
  end

  always @(negedge clk) begin
    if (we) begin
      got_q.push_back(din);
      got_cyc.push_back(cyc);
    end
    if (ce) addr_q.push_back(addr);
    if (drain_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (we2) got2_q.push_back(din2);
    if (ce2) addr2_q.push_back(addr2);
    if (ddone2) done2_cnt++;
    if (ce && r_w_1) viol++;
    if (we && (full || ce)) viol++;
    if (ce2 && rw2) viol++;
    if (we2 && (full2 || ce2)) viol++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got_q.delete();
    got_cyc.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic fire(output int t0);
    busy = 1'b1;
    tick(2);
    busy = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    ok = (done_cnt != 0);
  endtask

  task automatic check_words(input string tag, input int n);
    compared++;
    if (got_q.size() !== n) begin
      mismatched++;
      $display("FAIL %s_count: got %0d words, want %0d", tag, got_q.size(), n);
    end
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== mem_word(32'(i))) begin
        mismatched++;
        $display("FAIL %s_din[%0d]: got %h want %h", tag, i, got_q[i], mem_word(32'(i)));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    busy  = 1'b0;
    full  = 1'b0;
    busy2 = 1'b0;
    full2 = 1'b0;
    tick(2);
    compared++;
    if ({ce, we, r_w_1, drain_busy, drain_done} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: got %b want 00000", {ce, we, r_w_1, drain_busy, drain_done});
    end
    compared++;
    if (addr !== 32'h0 || din !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_buses: got addr %h din %h want 0 0", addr, din);
    end
    reset = 1'b1;
    tick(3);
    compared++;
    if (drain_busy !== 1'b0 || got_q.size() != 0) begin
      mismatched++;
      $display("FAIL reset_idle: got busy %b words %0d want 0 0", drain_busy, got_q.size());
    end
  endtask

  task automatic test_basic();
    int t0;
    bit ok;
    use_seq = 1'b1;
    clear();
    fire(t0);
    wait_done(60, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL basic_done: got no drain_done want pulse");
    end
    check_words("basic", 6);
    for (int i = 0; i < got_cyc.size(); i++) begin
      compared++;
      if (got_cyc[i] !== t0 + 3 * (i + 1)) begin
        mismatched++;
        $display("FAIL basic_we_cycle[%0d]: got %0d want %0d", i, got_cyc[i] - t0, 3 * (i + 1));
      end
    end
    compared++;
    if (done_cyc !== t0 + 19) begin
      mismatched++;
      $display("FAIL basic_done_cycle: got %0d want 19", done_cyc - t0);
    end
    tick(1);
    compared++;
    if (drain_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_busy_after: got %b want 0", drain_busy);
    end
  endtask

  task automatic test_backpressure();
    int  t0;
    int  n = 0;
    use_seq = 1'b0;
    seed = $urandom;
    clear();
    fire(t0);
    tick(6);
    full = 1'b1;
    tick(5);
    full = 1'b0;
    tick(1);
    while (done_cnt == 0 && n < 400) begin
      full = ($urandom_range(0, 2) == 0);
      tick(1);
      n++;
    end
    full = 1'b0;
    tick(2);
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL bp_done: got %0d pulses want 1", done_cnt);
    end
    check_words("bp", 6);
    compared++;
    if (got_cyc.size() < 2 || got_cyc[1] !== t0 + 11) begin
      mismatched++;
      $display("FAIL bp_word2_cycle: got %0d want %0d",
               (got_cyc.size() < 2) ? -1 : got_cyc[1] - t0, 11);
    end
  endtask

  task automatic test_retrigger();
    int t0;
    int t1;
    bit ok;
    use_seq = 1'b0;
    seed = $urandom;
    clear();
    fire(t0);
    tick(4);
    busy = 1'b1;
    tick(1);
    busy = 1'b0;
    wait_done(60, ok);
    tick(25);
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL retrig_done: got %0d pulses want 1", done_cnt);
    end
    check_words("retrig", 6);
    clear();
    fire(t1);
    wait_done(60, ok);
    compared++;
    if (addr_q.size() != 6 || addr_q[0] !== 32'h0) begin
      mismatched++;
      $display("FAIL retrig_fresh_addr: got %0d reads first %h want 6 reads from 0",
               addr_q.size(), (addr_q.size() != 0) ? addr_q[0] : 32'hx);
    end
    check_words("retrig2", 6);
  endtask

  task automatic test_reset_mid();
    int t0;
    use_seq = 1'b1;
    clear();
    fire(t0);
    tick(8);
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if ({ce, we, drain_busy, drain_done} !== 4'b0 || addr !== 32'h0 || din !== 32'h0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got ce%b we%b bsy%b dn%b addr %h din %h want all 0",
               ce, we, drain_busy, drain_done, addr, din);
    end
    compared++;
    if (got_q.size() !== 2) begin
      mismatched++;
      $display("FAIL midreset_words_before: got %0d want 2", got_q.size());
    end
    tick(1);
    reset = 1'b1;
    tick(12);
    compared++;
    if (got_q.size() !== 2 || drain_busy !== 1'b0 || done_cnt !== 0) begin
      mismatched++;
      $display("FAIL midreset_no_resume: got words %0d busy %b done %0d want 2 0 0",
               got_q.size(), drain_busy, done_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a[4];
    int n = 0;
    exp_a[0] = 32'hFFFF_FFFE;
    exp_a[1] = 32'hFFFF_FFFF;
    exp_a[2] = 32'h0;
    exp_a[3] = 32'h1;
    use_seq = 1'b0;
    seed = $urandom;
    got2_q.delete();
    addr2_q.delete();
    done2_cnt = 0;
    busy2 = 1'b1;
    tick(2);
    busy2 = 1'b0;
    while (done2_cnt == 0 && n < 60) begin
      tick(1);
      n++;
    end
    compared++;
    if (addr2_q.size() !== 4 || got2_q.size() !== 4) begin
      mismatched++;
      $display("FAIL wrap_count: got %0d reads %0d writes want 4 4", addr2_q.size(), got2_q.size());
    end
    for (int i = 0; i < 4 && i < addr2_q.size() && i < got2_q.size(); i++) begin
      compared++;
      if (addr2_q[i] !== exp_a[i] || got2_q[i] !== mem_word(exp_a[i])) begin
        mismatched++;
        $display("FAIL wrap[%0d]: got addr %h data %h want %h %h", i, addr2_q[i], got2_q[i],
                 exp_a[i], mem_word(exp_a[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    for (int k = 0; k < 3; k++) test_backpressure();
    test_retrigger();
    test_reset_mid();
    test_wrap();
    compared++;
    if (viol !== 0) begin
      mismatched++;
      $display("FAIL strobe_rules: got %0d violations want 0", viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
